// File: rtl/rgbw_frame_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : rgbw_frame_sched
// Purpose  : Two-source RGBW pixel frame scheduler feeding a write FIFO.
//            Grants one source per frame and forwards its GRB pixels as
//            tagged 32-bit FIFO words. Truncates over-long frames and times
//            out stalled frames. Every completed or timed-out frame is
//            closed with a stream-reset word (32'hC000_0000).
// Options  : RGBW_SCHED_RR_EN - round-robin arbitration between the two
//            sources. When undefined, s0 has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module rgbw_frame_sched #(
  parameter int MAX_PIXELS    = 300,
  parameter int WATCHDOG_CLKS = 9600
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_s0_valid,
  input  logic        in_s1_valid,
  input  logic [23:0] in_s0_data,
  input  logic [23:0] in_s1_data,
  input  logic        in_s0_last,
  input  logic        in_s1_last,
  output logic        out_s0_ready,
  output logic        out_s1_ready,
  input  logic        in_wr_fifo_full,
  output logic        out_wr_fifo_en,
  output logic [31:0] out_wr_fifo_data,
  output logic [1:0]  out_grant,
  output logic        out_frame_abort,
  output logic        out_busy
);

  localparam int CNT_W = $clog2(MAX_PIXELS + 1);
  localparam int WD_W  = $clog2(WATCHDOG_CLKS + 1);

  // Count values compared before the increment, so the compare fires on the
  // transfer / idle clock that makes the counter reach its limit.
  localparam logic [CNT_W-1:0] C_PIX_LAST = CNT_W'(MAX_PIXELS - 1);
  localparam logic [CNT_W-1:0] C_PIX_ONE  = CNT_W'(1);
  localparam logic [WD_W-1:0]  C_WD_LAST  = WD_W'(WATCHDOG_CLKS - 1);
  localparam logic [WD_W-1:0]  C_WD_ONE   = WD_W'(1);

  localparam logic [31:0] C_RST_WORD  = 32'hC000_0000;
  localparam logic [7:0]  C_PIX_TAG   = 8'h80;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_STREAM   = 2'd1;
  localparam logic [1:0] S_DRAIN    = 2'd2;
  localparam logic [1:0] S_RST_WORD = 2'd3;

  logic [1:0]       state_q,   state_d;
  logic [1:0]       grant_q,   grant_d;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [WD_W-1:0]  wd_cnt_q,  wd_cnt_d;
`ifdef RGBW_SCHED_RR_EN
  // 0: s0 wins a tie, 1: s1 wins a tie
  logic             prio_q,    prio_d;
`endif

  logic [1:0]  arb_pick;
  logic        own_valid;
  logic        own_last;
  logic [23:0] own_data;
  logic        own_ready;
  logic        xfer;
  logic        pix_limit_hit;
  logic        wd_tick;
  logic        wd_expire;

  // Route the current owner's handshake signals onto a single channel
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = 24'h0;
    if (grant_q[0]) begin
      own_valid = in_s0_valid;
      own_last  = in_s0_last;
      own_data  = in_s0_data;
    end else if (grant_q[1]) begin
      own_valid = in_s1_valid;
      own_last  = in_s1_last;
      own_data  = in_s1_data;
    end
  end

  // Pick the next frame owner from the sources requesting in IDLE
  always_comb begin
    arb_pick = 2'b00;
    if (in_s0_valid && in_s1_valid) begin
`ifdef RGBW_SCHED_RR_EN
      arb_pick = prio_q ? 2'b10 : 2'b01;
`else
      arb_pick = 2'b01;
`endif
    end else if (in_s0_valid) begin
      arb_pick = 2'b01;
    end else if (in_s1_valid) begin
      arb_pick = 2'b10;
    end
  end

  // DRAIN swallows words regardless of FIFO state; STREAM honours back-pressure
  assign own_ready = ((state_q == S_STREAM) && !in_wr_fifo_full) ||
                     (state_q == S_DRAIN);
  assign xfer      = own_valid && own_ready;

  // A non-last word that fills the frame budget truncates the frame
  assign pix_limit_hit = (state_q == S_STREAM) && xfer && !own_last &&
                         (pix_cnt_q == C_PIX_LAST);

  // Idle clocks only count when the FIFO could have taken a word
  assign wd_tick   = (state_q == S_STREAM) && !own_valid && !in_wr_fifo_full;
  assign wd_expire = wd_tick && (wd_cnt_q == C_WD_LAST);

  // State and bookkeeping registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      grant_q   <= 2'b00;
      pix_cnt_q <= '0;
      wd_cnt_q  <= '0;
`ifdef RGBW_SCHED_RR_EN
      prio_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      pix_cnt_q <= pix_cnt_d;
      wd_cnt_q  <= wd_cnt_d;
`ifdef RGBW_SCHED_RR_EN
      prio_q    <= prio_d;
`endif
    end
  end

  // Next-state, grant, counters and arbitration pointer
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    pix_cnt_d = pix_cnt_q;
    wd_cnt_d  = wd_cnt_q;
`ifdef RGBW_SCHED_RR_EN
    prio_d    = prio_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (arb_pick != 2'b00) begin
          grant_d   = arb_pick;
          pix_cnt_d = '0;
          wd_cnt_d  = '0;
          state_d   = S_STREAM;
        end
      end
      S_STREAM: begin
        if (xfer) begin
          wd_cnt_d  = '0;
          pix_cnt_d = pix_cnt_q + C_PIX_ONE;
          if (own_last) begin
            state_d = S_RST_WORD;
          end else if (pix_limit_hit) begin
            state_d = S_DRAIN;
          end
        end else if (wd_tick) begin
          if (wd_expire) begin
            state_d = S_RST_WORD;
          end else begin
            wd_cnt_d = wd_cnt_q + C_WD_ONE;
          end
        end
      end
      S_DRAIN: begin
        if (xfer && own_last) begin
          state_d = S_RST_WORD;
        end
      end
      S_RST_WORD: begin
        if (!in_wr_fifo_full) begin
          grant_d = 2'b00;
          state_d = S_IDLE;
`ifdef RGBW_SCHED_RR_EN
          // The source that just finished yields the next tie
          prio_d  = grant_q[0];
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  // Handshake, FIFO write and abort outputs decoded from the current state
  always_comb begin
    out_s0_ready     = 1'b0;
    out_s1_ready     = 1'b0;
    out_wr_fifo_en   = 1'b0;
    out_wr_fifo_data = 32'h0;
    out_frame_abort  = 1'b0;
    case (state_q)
      S_STREAM: begin
        out_s0_ready    = grant_q[0] && !in_wr_fifo_full;
        out_s1_ready    = grant_q[1] && !in_wr_fifo_full;
        out_frame_abort = pix_limit_hit || wd_expire;
        if (xfer) begin
          out_wr_fifo_en   = 1'b1;
          out_wr_fifo_data = {C_PIX_TAG, own_data};
        end
      end
      S_DRAIN: begin
        out_s0_ready = grant_q[0];
        out_s1_ready = grant_q[1];
      end
      S_RST_WORD: begin
        if (!in_wr_fifo_full) begin
          out_wr_fifo_en   = 1'b1;
          out_wr_fifo_data = C_RST_WORD;
        end
      end
      default: begin
      end
    endcase
  end

  assign out_grant = grant_q;
  assign out_busy  = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rgbw_frame_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_rgbw_frame_sched
// Purpose  : Scoreboard bench for rgbw_frame_sched (MAX_PIXELS=4,
//            WATCHDOG_CLKS=16). Expectations honour RGBW_SCHED_RR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rgbw_frame_sched;

  localparam logic [31:0] M_GNT  = 32'h60;
  localparam logic [31:0] G_S0   = 32'h20;
  localparam logic [31:0] G_S1   = 32'h40;
  localparam logic [31:0] M_BUSY = 32'h10;
  localparam logic [31:0] M_R0   = 32'h08;
  localparam logic [31:0] M_R1   = 32'h04;
  localparam logic [31:0] M_AB   = 32'h02;
  localparam logic [31:0] M_EN   = 32'h01;
  localparam logic [31:0] M_ALL  = 32'h7F;
  localparam logic [31:0] M_WORD = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_s0_valid = 1'b0;
  logic        in_s1_valid = 1'b0;
  logic [23:0] in_s0_data = 24'h0;
  logic [23:0] in_s1_data = 24'h0;
  logic        in_s0_last = 1'b0;
  logic        in_s1_last = 1'b0;
  logic        in_wr_fifo_full = 1'b0;
  logic        out_s0_ready;
  logic        out_s1_ready;
  logic        out_wr_fifo_en;
  logic [31:0] out_wr_fifo_data;
  logic [1:0]  out_grant;
  logic        out_frame_abort;
  logic        out_busy;

  rgbw_frame_sched #(
    .MAX_PIXELS    (4),
    .WATCHDOG_CLKS (16)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_s0_valid      (in_s0_valid),
    .in_s1_valid      (in_s1_valid),
    .in_s0_data       (in_s0_data),
    .in_s1_data       (in_s1_data),
    .in_s0_last       (in_s0_last),
    .in_s1_last       (in_s1_last),
    .out_s0_ready     (out_s0_ready),
    .out_s1_ready     (out_s1_ready),
    .in_wr_fifo_full  (in_wr_fifo_full),
    .out_wr_fifo_en   (out_wr_fifo_en),
    .out_wr_fifo_data (out_wr_fifo_data),
    .out_grant        (out_grant),
    .out_frame_abort  (out_frame_abort),
    .out_busy         (out_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  gnt;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          abort_exp = 0;
  int          abort_seen = 0;
  int          probe_seq = 0;
  int          probe_seen = 0;
  int          probe_kind = 0;
  logic [31:0] probe_mask = 32'h0;
  logic [31:0] probe_exp = 32'h0;
  string       probe_name = "";

  logic [23:0] t3_px [6] = '{24'hA00001, 24'hA00002, 24'hA00003,
                              24'hA00004, 24'hA00005, 24'hA00006};
  logic [31:0] t3_exp [4] = '{32'h80A00001, 32'h80A00002,
                               32'h80A00003, 32'h80A00004};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic v, input logic [23:0] d, input logic l);
    if (k == 0) begin
      in_s0_valid = v; in_s0_data = d; in_s0_last = l;
    end else begin
      in_s1_valid = v; in_s1_data = d; in_s1_last = l;
    end
  endtask

  // Hand a one-shot comparison to the monitor; it is evaluated at the next negedge
  task automatic probe(input string name, input int kind, input logic [31:0] mask,
                       input logic [31:0] expv);
    probe_name = name;
    probe_kind = kind;
    probe_mask = mask;
    probe_exp  = expv;
    probe_seq++;
    @(negedge clk);
    #1;
  endtask

  task automatic expect_word(input logic [31:0] d, input logic [1:0] g);
    exp_t e;
    e.data = d;
    e.gnt  = g;
    exp_q.push_back(e);
  endtask

  // Offer one word on source k and hold it until accepted (bounded)
  task automatic xfer(input int k, input logic [23:0] d, input logic l);
    logic r;
    int   n;
    drive(k, 1'b1, d, l);
    r = 1'b0;
    n = 0;
    while (!r && n < 64) begin
      @(negedge clk);
      r = (k == 0) ? out_s0_ready : out_s1_ready;
      @(posedge clk);
      #1;
      n++;
    end
    drive(k, 1'b0, 24'h0, 1'b0);
    if (!r) probe("xfer_timeout", 0, (k == 0) ? M_R0 : M_R1, (k == 0) ? M_R0 : M_R1);
  endtask

  // Monitor: scoreboard for FIFO writes and abort pulses, plus probe requests
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      if (out_wr_fifo_en === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL fifo_word got %h grant %b, expected no write", out_wr_fifo_data, out_grant);
        end else begin
          e = exp_q.pop_front();
          if (out_wr_fifo_data !== e.data || out_grant !== e.gnt) begin
            errors++;
            $display("FAIL fifo_word got %h grant %b, expected %h grant %b",
                     out_wr_fifo_data, out_grant, e.data, e.gnt);
          end
        end
      end
      if (out_frame_abort === 1'b1) begin
        checks++;
        if (abort_seen >= abort_exp) begin
          errors++;
          $display("FAIL frame_abort got unexpected pulse, expected none");
        end
        abort_seen++;
      end
      if (probe_seq != probe_seen) begin
        probe_seen = probe_seq;
        case (probe_kind)
          0:       act = {25'h0, out_grant, out_busy, out_s0_ready, out_s1_ready,
                          out_frame_abort, out_wr_fifo_en};
          1:       act = out_wr_fifo_data;
          default: act = {16'(exp_q.size()), 16'(abort_exp - abort_seen)};
        endcase
        checks++;
        if ((act & probe_mask) !== (probe_exp & probe_mask)) begin
          errors++;
          $display("FAIL %s got %h expected %h (mask %h)", probe_name,
                   act & probe_mask, probe_exp & probe_mask, probe_mask);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got no finish, expected finish before 1 ms");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Reset state
    tick();
    probe("reset_outputs", 0, M_ALL, 32'h0);
    tick();
    probe("reset_data", 1, M_WORD, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Three-pixel frame from s0
    expect_word(32'h8010_2030, 2'b01);
    expect_word(32'h8040_5060, 2'b01);
    expect_word(32'h8070_8090, 2'b01);
    expect_word(32'hC000_0000, 2'b01);
    drive(0, 1'b1, 24'h102030, 1'b0);
    probe("idle_no_accept", 0, M_BUSY | M_R0 | M_EN, 32'h0);
    tick();
    probe("stream_grant_s0", 0, M_GNT | M_BUSY | M_R0 | M_R1, G_S0 | M_BUSY | M_R0);
    tick();
    xfer(0, 24'h405060, 1'b0);
    xfer(0, 24'h708090, 1'b1);
    probe("rst_word_cycle", 0, M_GNT | M_BUSY | M_EN, G_S0 | M_BUSY | M_EN);
    tick();
    probe("idle_after_frame", 0, M_GNT | M_BUSY | M_EN, 32'h0);
    tick();

    // Simultaneous requests, back-to-back frames
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    expect_word(32'h8011_1111, 2'b01);
    expect_word(32'hC000_0000, 2'b01);
`ifdef RGBW_SCHED_RR_EN
    expect_word(32'h8033_3333, 2'b10);
    expect_word(32'hC000_0000, 2'b10);
    expect_word(32'h8022_2222, 2'b01);
    expect_word(32'hC000_0000, 2'b01);
`else
    expect_word(32'h8022_2222, 2'b01);
    expect_word(32'hC000_0000, 2'b01);
    expect_word(32'h8033_3333, 2'b10);
    expect_word(32'hC000_0000, 2'b10);
`endif
    fork
      begin
        xfer(0, 24'h111111, 1'b1);
        xfer(0, 24'h222222, 1'b1);
      end
      begin
        xfer(1, 24'h333333, 1'b1);
      end
    join
    tick();
    probe("idle_after_arb", 0, M_GNT | M_BUSY, 32'h0);
    tick();

    // Six-pixel s1 frame truncated at four
    for (int i = 0; i < 4; i++) expect_word(t3_exp[i], 2'b10);
    abort_exp++;
    expect_word(32'hC000_0000, 2'b10);
    for (int i = 0; i < 4; i++) xfer(1, t3_px[i], 1'b0);
    in_wr_fifo_full = 1'b1;
    drive(1, 1'b1, t3_px[4], 1'b0);
    probe("drain_ready_full", 0, M_GNT | M_BUSY | M_R1 | M_EN, G_S1 | M_BUSY | M_R1);
    tick();
    in_wr_fifo_full = 1'b0;
    xfer(1, t3_px[5], 1'b1);
    probe("rst_word_after_drain", 0, M_EN | M_AB, M_EN);
    tick();

    // FIFO full for 10 clocks mid-frame
    expect_word(32'h8011_2233, 2'b01);
    expect_word(32'h8044_5566, 2'b01);
    expect_word(32'h8077_8899, 2'b01);
    expect_word(32'hC000_0000, 2'b01);
    xfer(0, 24'h112233, 1'b0);
    drive(0, 1'b1, 24'h445566, 1'b0);
    in_wr_fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      probe("full_hold_valid", 0, M_R0 | M_EN | M_BUSY, M_BUSY);
      tick();
    end
    drive(0, 1'b0, 24'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      probe("full_hold_idle", 0, M_R0 | M_EN | M_AB, 32'h0);
      tick();
    end
    in_wr_fifo_full = 1'b0;
    for (int i = 0; i < 12; i++) begin
      probe("wd_not_expired", 0, M_AB | M_BUSY, M_BUSY);
      tick();
    end
    xfer(0, 24'h445566, 1'b0);
    xfer(0, 24'h778899, 1'b1);
    tick();

    // Watchdog expiry after 16 idle clocks
    expect_word(32'h805A_5A5A, 2'b01);
    abort_exp++;
    expect_word(32'hC000_0000, 2'b01);
    xfer(0, 24'h5A5A5A, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      probe("wd_count", 0, M_AB | M_EN | M_BUSY, ((i == 16) ? M_AB : 32'h0) | M_BUSY);
      tick();
    end
    probe("wd_rst_word", 0, M_GNT | M_BUSY | M_AB | M_EN, G_S0 | M_BUSY | M_EN);
    tick();
    probe("wd_back_idle", 0, M_GNT | M_BUSY, 32'h0);
    tick();

    // Reset mid-frame, then a fresh frame
    expect_word(32'h8001_0203, 2'b01);
    expect_word(32'h8004_0506, 2'b01);
    xfer(0, 24'h010203, 1'b0);
    xfer(0, 24'h040506, 1'b0);
    drive(0, 1'b1, 24'h070809, 1'b0);
    rst_n = 1'b0;
    probe("reset_mid_frame", 0, M_ALL, 32'h0);
    tick();
    probe("reset_mid_data", 1, M_WORD, 32'h0);
    tick();
    rst_n = 1'b1;
    expect_word(32'h800A_0B0C, 2'b01);
    expect_word(32'hC000_0000, 2'b01);
    xfer(0, 24'h0A0B0C, 1'b1);
    tick();
    tick();
    probe("scoreboard_empty", 2, M_WORD, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rgbw_frame_sched.md
RGBW_FRAME_SCHED -- requirements
Module: rgbw_frame_sched

Interface
REQ-001 SHALL have parameter MAX_PIXELS, default 300: maximum pixel words accepted per frame.
REQ-002 SHALL have parameter WATCHDOG_CLKS, default 9600 (100 us at 96 MHz): mid-frame idle limit in clocks.
REQ-003 SHALL have ports clk (input, 1): single clock, 96 MHz, also the FIFO w_clk.
REQ-004 SHALL have rst_n (input, 1): reset, asynchronous, active-low.
REQ-005 SHALL have in_s0_valid, in_s1_valid (input, 1 each): source k offers a pixel.
REQ-006 SHALL have in_s0_data, in_s1_data (input, 24 each): GRB pixel, G in [23:16], R in [15:8], B in [7:0].
REQ-007 SHALL have in_s0_last, in_s1_last (input, 1 each): the offered pixel is the last of its frame.
REQ-008 SHALL have out_s0_ready, out_s1_ready (output, 1 each): source k transfer accepted this cycle when valid is also high.
REQ-009 SHALL have in_wr_fifo_full (input, 1): FIFO write side full.
REQ-010 SHALL have out_wr_fifo_en (output, 1): FIFO write strobe.
REQ-011 SHALL have out_wr_fifo_data (output, 32): FIFO word, bit31 valid, bit30 stream_reset, [29:24] zero, [23:0] GRB.
REQ-012 SHALL have out_grant (output, 2): one-hot owner of the current frame, 2'b00 when none.
REQ-013 SHALL have out_frame_abort (output, 1): one-clock pulse when a frame is truncated or timed out.
REQ-014 SHALL have out_busy (output, 1): high in any state other than IDLE.

Function
REQ-015 SHALL implement states IDLE, STREAM, DRAIN and RST_WORD.
REQ-016 IDLE: when any in_sk_valid is high, SHALL register the grant and enter STREAM on the next edge; arbitration latency is 1 clock, and no data is accepted in IDLE.
REQ-017 SHALL assert out_sk_ready combinationally only when state is STREAM, out_grant[k] is set and !in_wr_fifo_full; the non-owner's ready SHALL be 0.
REQ-018 On each STREAM transfer (valid&ready), SHALL combinationally assert out_wr_fifo_en with out_wr_fifo_data = {2'b10, 6'b0, data}, giving zero latency and never writing while full.
REQ-019 Per-frame pixel counter SHALL clear on grant and increment per STREAM transfer.
REQ-020 A transfer with last SHALL move the block to RST_WORD.
REQ-021 If the counter reaches MAX_PIXELS without last, SHALL pulse out_frame_abort and enter DRAIN.
REQ-022 DRAIN: owner ready SHALL be 1 regardless of full, with no FIFO write; accepted words are discarded until last is accepted, then the block enters RST_WORD.
REQ-023 Watchdog SHALL count STREAM clocks with owner valid low, clearing on any transfer; clocks stalled by full SHALL NOT count.
REQ-024 When the watchdog reaches WATCHDOG_CLKS, SHALL pulse out_frame_abort and enter RST_WORD.
REQ-025 RST_WORD: when !in_wr_fifo_full, SHALL write 32'hC000_0000 for 1 clock, clear out_grant, update arbitration priority and return to IDLE; while full, SHALL hold.
REQ-026 A single-pixel frame (last on the first word) SHALL produce exactly one pixel word followed by one reset word.
REQ-027 Unknown state SHALL recover to IDLE with grant cleared.

Reset
REQ-028 While rst_n is low, SHALL hold state IDLE, out_grant 0, out_wr_fifo_en 0, out_wr_fifo_data 0, all ready 0, out_frame_abort 0, out_busy 0, counters 0 and priority pointer to s0.
REQ-029 Reset mid-frame SHALL abandon the frame with no reset word emitted; operation SHALL resume on the first edge after rst_n rises.

Configuration
REQ-030 With macro RGBW_SCHED_RR_EN defined, SHALL use round-robin arbitration: after a frame from sk, the other source wins a simultaneous request.
REQ-031 Without RGBW_SCHED_RR_EN, SHALL use fixed priority: s0 wins every simultaneous request, and the pointer is unused.

Verification
REQ-032 SHALL cover: s0 sends 3 pixels 0x102030,0x405060,0x708090 with last on the third -> FIFO receives 0x80102030, 0x80405060, 0x80708090, 0xC0000000; out_grant=01 throughout.
REQ-033 SHALL cover: both valid in IDLE for two back-to-back frames -> RR grants s0 then s1, while fixed priority grants s0 then s0.
REQ-034 SHALL cover: MAX_PIXELS=4 and a 6-pixel s1 frame -> 4 writes, abort pulse, 2 words discarded, then 0xC0000000.
REQ-035 SHALL cover: in_wr_fifo_full held 10 clocks mid-frame -> ready low, no writes, no watchdog advance; resumes with no word lost or duplicated.
REQ-036 SHALL cover: WATCHDOG_CLKS=16 with owner valid low 16 clocks -> abort pulse, 0xC0000000 written, IDLE.
REQ-037 SHALL cover: rst_n low after 2 pixels -> outputs 0 immediately, no reset word written, and a new frame is accepted afterwards.
